// File: rtl/axi2mem_sram_if.sv
// Request/response bundle between the AXI-to-memory adapter and the SRAM model.
//   mem_wr_en / mem_wstrb / mem_waddr / mem_wdata : byte-strobed write request
//   mem_rd_en / mem_raddr                         : read request
//   mem_rdata                                     : read data returned by the SRAM
// master : adapter side (drives requests, receives mem_rdata)
// slave  : SRAM side (receives requests, drives mem_rdata)
interface axi2mem_sram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  mem_wr_en;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_wr_en, mem_wstrb, mem_waddr, mem_wdata, mem_rd_en, mem_raddr,
        input  mem_rdata
    );

    modport slave (
        input  mem_wr_en, mem_wstrb, mem_waddr, mem_wdata, mem_rd_en, mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/axi2mem_sram.sv
// Synchronous single-clock SRAM model placed behind the AXI-to-memory adapter.
// Byte-strobed writes, write-first read-during-write, READ_LATENCY-deep read
// pipeline, sticky out-of-range error capture and saturating access counters.
// Ports:
//   aclk, aresetn  : clock (rising edge), asynchronous active-low reset
//   mem            : request/response bundle (slave side)
//   err_clr_i      : single-cycle pulse clearing the error status
//   err_o          : sticky out-of-range flag
//   err_addr_o     : byte address of the first out-of-range access since clear
//   err_is_wr_o    : that first error was a write
//   wr_cnt_o       : accepted in-range writes, saturating
//   rd_cnt_o       : accepted in-range reads, saturating
module axi2mem_sram #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axi2mem_sram_if.slave         mem,
    input  logic                  err_clr_i,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_is_wr_o,
    output logic [31:0]           wr_cnt_o,
    output logic [31:0]           rd_cnt_o
);
    localparam int unsigned LANE_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - LANE_BITS;
    localparam int unsigned MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [IDX_WIDTH-1:0]  widx, ridx;
    logic                  w_in, r_in;
    logic                  wr_go, rd_go, wr_oor, rd_oor;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_lsb;

    logic [DATA_WIDTH-1:0] ram [MEM_WORDS];

    logic                  pipe_v [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

    // Low address bits select a byte lane only and are ignored.
    assign unused_lsb = ^{mem.mem_waddr, mem.mem_raddr};

    assign widx   = mem.mem_waddr[ADDR_WIDTH-1:LANE_BITS];
    assign ridx   = mem.mem_raddr[ADDR_WIDTH-1:LANE_BITS];
    assign w_in   = 32'(widx) < MEM_WORDS;
    assign r_in   = 32'(ridx) < MEM_WORDS;
    assign wr_go  = mem.mem_wr_en & w_in;
    assign rd_go  = mem.mem_rd_en & r_in;
    assign wr_oor = mem.mem_wr_en & ~w_in;
    assign rd_oor = mem.mem_rd_en & ~r_in;

    // Array is deliberately not reset so contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (wr_go) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (mem.mem_wstrb[b]) begin
                    ram[widx[MEM_AW-1:0]][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write-first bypass per byte lane; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (r_in) begin
            rd_word = ram[ridx[MEM_AW-1:0]];
            if (wr_go && (widx == ridx)) begin
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                    if (mem.mem_wstrb[b]) begin
                        rd_word[8*b +: 8] = mem.mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Each data stage loads only behind a valid stage, so the final data
    // stage doubles as the mem_rdata output register that holds between reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= mem.mem_rd_en;
            if (mem.mem_rd_en) begin
                pipe_d[0] <= rd_word;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign mem.mem_rdata = pipe_d[READ_LATENCY-1];

    // A new error wins over a same-cycle clear; a write error wins over a read error.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_o       <= 1'b0;
            err_addr_o  <= '0;
            err_is_wr_o <= 1'b0;
        end else if ((wr_oor || rd_oor) && (!err_o || err_clr_i)) begin
            err_o       <= 1'b1;
            err_addr_o  <= wr_oor ? mem.mem_waddr : mem.mem_raddr;
            err_is_wr_o <= wr_oor;
        end else if (err_clr_i) begin
            err_o       <= 1'b0;
            err_addr_o  <= '0;
            err_is_wr_o <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_cnt_o <= '0;
            rd_cnt_o <= '0;
        end else begin
            if (wr_go && (wr_cnt_o != '1)) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end
            if (rd_go && (rd_cnt_o != '1)) begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi2mem_sram.sv
// Self-checking bench for axi2mem_sram: two instances (READ_LATENCY 1 and 3)
// receive identical stimulus; a behavioural model predicts every output.
module tb_axi2mem_sram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;

    logic        err1, eiw1, err3, eiw3;
    logic [15:0] eaddr1, eaddr3;
    logic [31:0] wc1, rc1, wc3, rc3;

    int total = 0;
    int bad   = 0;

    axi2mem_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus1 ();
    axi2mem_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus3 ();

    axi2mem_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(4096), .READ_LATENCY(1)) dut1 (
        .aclk(clk), .aresetn(rst_n), .mem(bus1), .err_clr_i(err_clr),
        .err_o(err1), .err_addr_o(eaddr1), .err_is_wr_o(eiw1),
        .wr_cnt_o(wc1), .rd_cnt_o(rc1)
    );

    axi2mem_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(4096), .READ_LATENCY(3)) dut3 (
        .aclk(clk), .aresetn(rst_n), .mem(bus3), .err_clr_i(err_clr),
        .err_o(err3), .err_addr_o(eaddr3), .err_is_wr_o(eiw3),
        .wr_cnt_o(wc3), .rd_cnt_o(rc3)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [31:0] mref [256];
    bit        hist_v [2048];
    bit [31:0] hist_d [2048];
    int        ecount   = 0;
    int        rst_edge = 0;
    bit        m_err    = 0;
    bit [15:0] m_eaddr  = '0;
    bit        m_eiw    = 0;
    bit [31:0] m_wcnt   = '0;
    bit [31:0] m_rcnt   = '0;

    // Output after edge e of a latency-L memory: the most recent read issued
    // at or before edge e-L+1 since reset, else zero.
    function automatic logic [31:0] exp_out(input int e, input int lat);
        for (int j = e - lat + 1; j > rst_edge; j--) begin
            if (hist_v[j]) return hist_d[j];
        end
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic wr, input logic [3:0] strb, input logic [15:0] waddr,
                           input logic [31:0] wdata, input logic rd, input logic [15:0] raddr);
        bus1.mem_wr_en = wr;  bus3.mem_wr_en = wr;
        bus1.mem_wstrb = strb; bus3.mem_wstrb = strb;
        bus1.mem_waddr = waddr; bus3.mem_waddr = waddr;
        bus1.mem_wdata = wdata; bus3.mem_wdata = wdata;
        bus1.mem_rd_en = rd;  bus3.mem_rd_en = rd;
        bus1.mem_raddr = raddr; bus3.mem_raddr = raddr;
    endtask

    task automatic check_all();
        chk("rdata_l1", bus1.mem_rdata, exp_out(ecount, 1));
        chk("rdata_l3", bus3.mem_rdata, exp_out(ecount, 3));
        chk("err_l1", 32'(err1), 32'(m_err));
        chk("err_l3", 32'(err3), 32'(m_err));
        chk("eaddr_l1", 32'(eaddr1), 32'(m_eaddr));
        chk("eaddr_l3", 32'(eaddr3), 32'(m_eaddr));
        chk("eiw_l1", 32'(eiw1), 32'(m_eiw));
        chk("eiw_l3", 32'(eiw3), 32'(m_eiw));
        chk("wcnt_l1", wc1, m_wcnt);
        chk("wcnt_l3", wc3, m_wcnt);
        chk("rcnt_l1", rc1, m_rcnt);
        chk("rcnt_l3", rc3, m_rcnt);
    endtask

    // One clock of stimulus; model applied at the edge, outputs checked 1 time unit later.
    task automatic step(input logic wr, input logic [3:0] strb, input logic [15:0] waddr,
                        input logic [31:0] wdata, input logic rd, input logic [15:0] raddr,
                        input logic clr);
        int unsigned widx, ridx;
        bit          win, rin, ew, er;
        bit [31:0]   d;
        @(negedge clk);
        set_bus(wr, strb, waddr, wdata, rd, raddr);
        err_clr = clr;
        @(posedge clk);
        ecount++;
        widx = 32'(waddr) >> 2;
        ridx = 32'(raddr) >> 2;
        win  = widx < 4096;
        rin  = ridx < 4096;
        d    = '0;
        if (rd && rin) begin
            d = mref[ridx[7:0]];
            for (int b = 0; b < 4; b++)
                if (wr && win && (widx == ridx) && strb[b]) d[8*b +: 8] = wdata[8*b +: 8];
        end
        hist_v[ecount] = rd;
        hist_d[ecount] = d;
        if (wr && win) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mref[widx[7:0]][8*b +: 8] = wdata[8*b +: 8];
        end
        ew = wr && !win;
        er = rd && !rin;
        if ((ew || er) && (!m_err || clr)) begin
            m_err   = 1;
            m_eaddr = ew ? waddr : raddr;
            m_eiw   = ew;
        end else if (clr) begin
            m_err = 0; m_eaddr = '0; m_eiw = 0;
        end
        if (wr && win && m_wcnt != 32'hFFFF_FFFF) m_wcnt++;
        if (rd && rin && m_rcnt != 32'hFFFF_FFFF) m_rcnt++;
        #1;
        check_all();
        set_bus(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        m_err = 0; m_eaddr = '0; m_eiw = 0; m_wcnt = '0; m_rcnt = '0;
        chk("rst_rdata_l1", bus1.mem_rdata, 32'h0);
        chk("rst_rdata_l3", bus3.mem_rdata, 32'h0);
        chk("rst_err", 32'(err1 | err3), 32'h0);
        chk("rst_cnt", wc1 | rc1 | wc3 | rc3, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rst_edge = ecount;
    endtask

    initial begin
        logic [15:0] a, ra;
        set_bus(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);

        // Power-on reset
        do_reset();
        idle(2);

        // Basic write then read
        step(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0010, 1'b0);
        chk("tp_basic_rdata", bus1.mem_rdata, 32'hDEADBEEF);
        chk("tp_basic_wcnt", wc1, 32'd1);
        chk("tp_basic_rcnt", rc1, 32'd1);

        // Byte strobes
        step(1'b1, 4'hF, 16'h0020, 32'h11223344, 1'b0, 16'h0, 1'b0);
        step(1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD, 1'b0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0020, 1'b0);
        chk("tp_strobe_rdata", bus1.mem_rdata, 32'h11BB33DD);

        // Read-during-write, same word
        step(1'b1, 4'hF, 16'h0030, 32'h00000000, 1'b0, 16'h0, 1'b0);
        step(1'b1, 4'b1100, 16'h0030, 32'hFFFF0000, 1'b1, 16'h0030, 1'b0);
        chk("tp_rdw_rdata", bus1.mem_rdata, 32'hFFFF0000);
        idle(3);

        // Out-of-range handling
        step(1'b1, 4'hF, 16'h4000, 32'h12345678, 1'b0, 16'h0, 1'b0);
        chk("tp_oor_err", 32'(err1), 32'h1);
        chk("tp_oor_eaddr", 32'(eaddr1), 32'h4000);
        chk("tp_oor_eiw", 32'(eiw1), 32'h1);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h5000, 1'b0);
        chk("tp_oor_rd_zero", bus1.mem_rdata, 32'h0);
        chk("tp_oor_eaddr_kept", 32'(eaddr1), 32'h4000);
        chk("tp_oor_wcnt", wc1, 32'd5);
        chk("tp_oor_rcnt", rc1, 32'd3);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b1);
        chk("tp_clr_err", 32'(err1), 32'h0);
        // Error coinciding with clear is captured
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h6004, 1'b0);
        step(1'b1, 4'hF, 16'h7000, 32'h0, 1'b1, 16'h6000, 1'b1);
        chk("tp_clr_new_err_eaddr", 32'(eaddr1), 32'h7000);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Preload the modelled region
        for (int w = 0; w < 256; w++) begin
            a = 16'(w << 2);
            step(1'b1, 4'hF, a, $urandom, 1'b0, 16'h0, 1'b0);
        end

        // Back-to-back read burst
        for (int w = 0; w < 8; w++) begin
            a = 16'(w << 2);
            step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, a, 1'b0);
        end
        idle(4);
        chk("tp_burst_hold_l3", bus3.mem_rdata, 32'(mref[7]));

        // Reset with two reads in flight
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0040, 1'b0);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0044, 1'b0);
        do_reset();
        idle(4);
        chk("tp_rst_flush_l3", bus3.mem_rdata, 32'h0);
        step(1'b0, 4'h0, 16'h0, 32'h0, 1'b1, 16'h0010, 1'b0);
        idle(2);
        chk("tp_rst_retain_l3", bus3.mem_rdata, 32'(mref[4]));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 16383) << 2)
                                              : 16'($urandom_range(0, 255) << 2);
            ra = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(4096, 16383) << 2)
                                              : (($urandom_range(0, 3) == 0) ? a
                                                 : 16'($urandom_range(0, 255) << 2));
            step(1'($urandom), 4'($urandom), a, $urandom, 1'($urandom), ra,
                 1'($urandom_range(0, 19) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
